// File: rtl/conv_pkg.sv
// Shared definitions for the 1-D convolution datapath (write and read sides).
package conv_pkg;

  localparam int unsigned DATA_N      = 8;
  localparam int unsigned LG_DATA_N   = 3;
  localparam int unsigned FILTER_N    = 4;
  localparam int unsigned LG_FILTER_N = 2;
  localparam int unsigned DATA_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    LOAD_X,
    FLUSH,
    BUSY
  } wr_state_e;

endpackage

// File: rtl/wr_addr_cnt.sv
// Write address counter: synchronous clear, count enable, terminal-count flag.
// Saturates at N-1 so an address never reaches N.
module wr_addr_cnt #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step until the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/control_mem_wr.sv
// Write-side controller for the convolution memories: takes a serial F-then-X
// stream, drives registered write ports, flags load completion.
// Optional feature: CONV_MEM_WR_LAST_CHK_EN adds s_last / load_err framing check.
module control_mem_wr #(
  parameter int unsigned DATA_N      = conv_pkg::DATA_N,
  parameter int unsigned LG_DATA_N   = conv_pkg::LG_DATA_N,
  parameter int unsigned FILTER_N    = conv_pkg::FILTER_N,
  parameter int unsigned LG_FILTER_N = conv_pkg::LG_FILTER_N,
  parameter int unsigned DATA_W      = conv_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  input  logic                   compute_done,
  output logic                   wr_en_f,
  output logic [LG_FILTER_N-1:0] wr_addr_f,
  output logic                   wr_en_x,
  output logic [LG_DATA_N-1:0]   wr_addr_x,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   mem_wr_state,
  output logic                   load_done
`ifdef CONV_MEM_WR_LAST_CHK_EN
  ,
  input  logic                   s_last,
  output logic                   load_err
`endif
);

  import conv_pkg::*;

  wr_state_e state_q, state_d;

  logic                   accept;
  logic                   cnt_clr;
  logic                   f_tc, x_tc;
  logic [LG_FILTER_N-1:0] f_cnt;
  logic [LG_DATA_N-1:0]   x_cnt;

  logic                   wr_en_f_q, wr_en_x_q, load_done_q;
  logic [LG_FILTER_N-1:0] wr_addr_f_q;
  logic [LG_DATA_N-1:0]   wr_addr_x_q;
  logic [DATA_W-1:0]      wr_data_q;

  assign accept  = s_valid & s_ready;
  assign cnt_clr = (state_q == IDLE) & start;

  wr_addr_cnt #(
    .N (FILTER_N),
    .W (LG_FILTER_N)
  ) u_f_cnt (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (cnt_clr),
    .en_i   (accept && (state_q == LOAD_F)),
    .cnt_o  (f_cnt),
    .tc_o   (f_tc)
  );

  wr_addr_cnt #(
    .N (DATA_N),
    .W (LG_DATA_N)
  ) u_x_cnt (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (cnt_clr),
    .en_i   (accept && (state_q == LOAD_X)),
    .cnt_o  (x_cnt),
    .tc_o   (x_tc)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: terminal-count accepts advance the load phases
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)          state_d = LOAD_F;
      LOAD_F:  if (accept && f_tc) state_d = LOAD_X;
      LOAD_X:  if (accept && x_tc) state_d = FLUSH;
      FLUSH:                       state_d = BUSY;
      BUSY:    if (compute_done)   state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    s_ready      = (state_q == LOAD_F) || (state_q == LOAD_X);
    mem_wr_state = (state_q == LOAD_F) || (state_q == LOAD_X) || (state_q == FLUSH);
  end

  // Registered write port and completion pulse, one cycle after the accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_f_q   <= 1'b0;
      wr_en_x_q   <= 1'b0;
      wr_addr_f_q <= '0;
      wr_addr_x_q <= '0;
      wr_data_q   <= '0;
      load_done_q <= 1'b0;
    end else begin
      wr_en_f_q   <= accept && (state_q == LOAD_F);
      wr_en_x_q   <= accept && (state_q == LOAD_X);
      load_done_q <= (state_q == FLUSH);
      if (accept) begin
        wr_data_q <= s_data;
        if (state_q == LOAD_F) begin
          wr_addr_f_q <= f_cnt;
        end else begin
          wr_addr_x_q <= x_cnt;
        end
      end
    end
  end

  assign wr_en_f   = wr_en_f_q;
  assign wr_en_x   = wr_en_x_q;
  assign wr_addr_f = wr_addr_f_q;
  assign wr_addr_x = wr_addr_x_q;
  assign wr_data   = wr_data_q;
  assign load_done = load_done_q;

`ifdef CONV_MEM_WR_LAST_CHK_EN
  logic load_err_q, load_err_d;
  logic final_x;

  assign final_x = (state_q == LOAD_X) && x_tc;

  // Sticky framing error: s_last must mark exactly the final X word
  always_comb begin
    load_err_d = load_err_q;
    if (cnt_clr) begin
      load_err_d = 1'b0;
    end else if (accept && (s_last != final_x)) begin
      load_err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;
`endif

endmodule

// File: tb/tb_control_mem_wr.sv
// Self-checking bench for control_mem_wr: directed vector table, multi-cycle
// corner sequences and randomized traffic against a word-count reference model.
module tb_control_mem_wr;

  localparam int F_N   = 4;
  localparam int D_N   = 8;
  localparam int TOTAL = F_N + D_N;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       compute_done = 1'b0;
  logic       s_ready;
  logic       wr_en_f, wr_en_x, mem_wr_state, load_done;
  logic [1:0] wr_addr_f;
  logic [2:0] wr_addr_x;
  logic [7:0] wr_data;
`ifdef CONV_MEM_WR_LAST_CHK_EN
  logic       s_last = 1'b0;
  logic       load_err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_mem_wr #(
    .DATA_N      (8),
    .LG_DATA_N   (3),
    .FILTER_N    (4),
    .LG_FILTER_N (2),
    .DATA_W      (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .compute_done (compute_done),
    .wr_en_f      (wr_en_f),
    .wr_addr_f    (wr_addr_f),
    .wr_en_x      (wr_en_x),
    .wr_addr_x    (wr_addr_x),
    .wr_data      (wr_data),
    .mem_wr_state (mem_wr_state),
    .load_done    (load_done)
`ifdef CONV_MEM_WR_LAST_CHK_EN
    ,
    .s_last       (s_last),
    .load_err     (load_err)
`endif
  );

  // Reference model: a load is a count of words taken, then one flush cycle,
  // then a busy period awaiting compute_done.
  bit         m_loading, m_flush, m_busy, m_err;
  int         m_n;
  bit         e_ready, e_wen_f, e_wen_x, e_done, e_mws;
  int         e_addr;
  logic [7:0] e_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_flush = 0; m_busy = 0; m_err = 0; m_n = 0;
  endtask

  function automatic bit model_idle();
    return !m_loading && !m_flush && !m_busy;
  endfunction

  task automatic model_edge(input bit st, input bit v, input bit cd, input bit lst,
                            input logic [7:0] d);
    bit acc, was_flush, was_idle;
    acc       = m_loading && v;
    was_flush = m_flush;
    was_idle  = model_idle();
    e_wen_f   = acc && (m_n < F_N);
    e_wen_x   = acc && (m_n >= F_N);
    e_addr    = (m_n < F_N) ? m_n : m_n - F_N;
    e_data    = d;
    if (was_idle && st) m_err = 0;
    else if (acc && (lst != (m_n == TOTAL - 1))) m_err = 1;
    if (acc) begin
      m_n++;
      if (m_n == TOTAL) begin
        m_loading = 0;
        m_flush   = 1;
      end
    end else if (m_flush) begin
      m_flush = 0;
      m_busy  = 1;
    end else if (m_busy) begin
      if (cd) m_busy = 0;
    end else if (was_idle && st) begin
      m_loading = 1;
      m_n       = 0;
    end
    e_done  = was_flush;
    e_ready = m_loading;
    e_mws   = m_loading || m_flush;
  endtask

  task automatic compare_model();
    chk("s_ready", int'(s_ready), int'(e_ready));
    chk("mem_wr_state", int'(mem_wr_state), int'(e_mws));
    chk("load_done", int'(load_done), int'(e_done));
    chk("wr_en_f", int'(wr_en_f), int'(e_wen_f));
    chk("wr_en_x", int'(wr_en_x), int'(e_wen_x));
    if (e_wen_f) begin
      chk("wr_addr_f", int'(wr_addr_f), e_addr);
      chk("wr_data_f", int'(wr_data), int'(e_data));
    end
    if (e_wen_x) begin
      chk("wr_addr_x", int'(wr_addr_x), e_addr);
      chk("wr_data_x", int'(wr_data), int'(e_data));
    end
`ifdef CONV_MEM_WR_LAST_CHK_EN
    chk("load_err", int'(load_err), int'(m_err));
`endif
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge
  task automatic cycle(input bit st, input bit v, input bit cd, input bit lst,
                       input logic [7:0] d);
    start        = st;
    s_valid      = v;
    compute_done = cd;
    s_data       = d;
`ifdef CONV_MEM_WR_LAST_CHK_EN
    s_last       = lst;
`endif
    model_edge(st, v, cd, lst, d);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic go_idle();
    int k;
    for (k = 0; k < 40 && !model_idle(); k++) begin
      cycle(0, 1, 1, (m_n == TOTAL - 1), 8'hEE);
    end
    chk("go_idle_bound", int'(model_idle()), 1);
  endtask

  typedef struct {
    bit         st, v, cd;
    logic [7:0] d;
    bit         r, wf, wx;
    int         a;
    bit         done, mws;
  } vec_t;

  vec_t tbl[17];
  int   lat;
  bit   seen;

  initial begin
    // Directed table: start, 12 words back to back, flush, busy, release
    for (int i = 0; i < 17; i++) tbl[i] = '{default: 0};
    tbl[0].st = 1; tbl[0].r = 1; tbl[0].mws = 1;
    for (int i = 1; i <= 12; i++) begin
      tbl[i].v   = 1;
      tbl[i].d   = 8'(16 + i - 1);
      tbl[i].r   = (i < 12);
      tbl[i].mws = 1;
      tbl[i].wf  = (i <= 4);
      tbl[i].wx  = (i > 4);
      tbl[i].a   = (i <= 4) ? i - 1 : i - 5;
    end
    tbl[13].v = 1; tbl[13].done = 1;
    tbl[14].v = 1;
    tbl[15].cd = 1;
    tbl[16].v = 1;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_wr_en_f", int'(wr_en_f), 0);
    chk("rst_wr_en_x", int'(wr_en_x), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_addr_f", int'(wr_addr_f), 0);
    chk("rst_addr_x", int'(wr_addr_x), 0);
    chk("rst_mws", int'(mem_wr_state), 0);
    chk("rst_load_done", int'(load_done), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].st, tbl[i].v, tbl[i].cd, (i == 12), tbl[i].d);
      chk("tbl_s_ready", int'(s_ready), int'(tbl[i].r));
      chk("tbl_mws", int'(mem_wr_state), int'(tbl[i].mws));
      chk("tbl_load_done", int'(load_done), int'(tbl[i].done));
      chk("tbl_wr_en_f", int'(wr_en_f), int'(tbl[i].wf));
      chk("tbl_wr_en_x", int'(wr_en_x), int'(tbl[i].wx));
      if (tbl[i].wf) chk("tbl_addr_f", int'(wr_addr_f), tbl[i].a);
      if (tbl[i].wx) chk("tbl_addr_x", int'(wr_addr_x), tbl[i].a);
      if (tbl[i].wf || tbl[i].wx) chk("tbl_data", int'(wr_data), int'(tbl[i].d));
    end

    // s_valid toggling every cycle: load_done 11 cycles later than back to back
    cycle(1, 0, 0, 0, 8'h00);
    seen = 0; lat = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      cycle(0, bit'(k % 2), 0, (m_n == TOTAL - 1), 8'(8'h40 + k));
      if (load_done) begin
        seen = 1;
        lat  = k;
      end
    end
    chk("toggle_latency", lat, 24);
    go_idle();

    // start/compute_done held high during LOAD and FLUSH have no effect
    cycle(1, 0, 0, 0, 8'h00);
    for (int w = 0; w < TOTAL; w++) cycle(1, 1, 1, (w == TOTAL - 1), 8'(8'hA0 + w));
    cycle(1, 1, 1, 0, 8'h55);        // FLUSH
    chk("flush_to_busy_done", int'(load_done), 1);
    cycle(0, 0, 1, 0, 8'h00);        // compute_done in BUSY
    chk("busy_to_idle_ready", int'(s_ready), 0);
    chk("busy_to_idle_mws", int'(mem_wr_state), 0);
    cycle(1, 0, 0, 0, 8'h00);        // back-to-back start honoured
    chk("b2b_start_ready", int'(s_ready), 1);
    for (int w = 0; w < TOTAL; w++) cycle(0, 1, 0, (w == TOTAL - 1), 8'(8'hC0 + w));
    cycle(0, 1, 0, 0, 8'h00);
    chk("b2b_load_done", int'(load_done), 1);
    cycle(0, 1, 0, 0, 8'h00);        // s_valid in BUSY ignored
    go_idle();

    // Asynchronous reset after 6 accepts
    cycle(1, 0, 0, 0, 8'h00);
    for (int w = 0; w < 6; w++) cycle(0, 1, 0, 0, 8'(8'h60 + w));
    start = 0; s_valid = 0; compute_done = 0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_s_ready", int'(s_ready), 0);
    chk("arst_wr_en_x", int'(wr_en_x), 0);
    chk("arst_wr_data", int'(wr_data), 0);
    chk("arst_addr_x", int'(wr_addr_x), 0);
    chk("arst_mws", int'(mem_wr_state), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    cycle(1, 0, 0, 0, 8'h00);
    cycle(0, 1, 0, 0, 8'h77);
    chk("post_rst_addr_f", int'(wr_addr_f), 0);
    chk("post_rst_wr_en_f", int'(wr_en_f), 1);
    go_idle();

`ifdef CONV_MEM_WR_LAST_CHK_EN
    // Framing check: s_last on 11th word errors; only on 12th is clean
    cycle(1, 0, 0, 0, 8'h00);
    for (int w = 0; w < TOTAL; w++) cycle(0, 1, 0, (w == 10), 8'(w));
    chk("last_early_err", int'(load_err), 1);
    go_idle();
    cycle(1, 0, 0, 0, 8'h00);
    chk("last_err_cleared", int'(load_err), 0);
    for (int w = 0; w < TOTAL; w++) cycle(0, 1, 0, (w == TOTAL - 1), 8'(w));
    chk("last_ok_no_err", int'(load_err), 0);
    go_idle();
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 7) == 0),
            (m_n == TOTAL - 1) ^ ($urandom_range(0, 49) == 0),
            8'($urandom));
      checks++;
      if (wr_en_f && wr_en_x) begin
        failures++;
        $display("FAIL wr_en_exclusive actual=both expected=at_most_one at %0t", $time);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
